// File: rtl/fir_pkg.sv
// Shared constants, state encoding and address helpers for the 11-tap FIR engine.
package fir_pkg;

  localparam int NTAP = 11;
  localparam int DW   = 32;
  localparam int AW   = 12;
  localparam int IW   = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_WAIT_X = 3'd2;
  localparam logic [2:0] S_MAC    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  // RAMs are byte addressed with one 32-bit word per index.
  function automatic logic [AW-1:0] byte_addr(input logic [IW-1:0] idx);
    return {{(AW-IW-2){1'b0}}, idx, 2'b00};
  endfunction

  function automatic logic [IW-1:0] dec_mod_ntap(input logic [IW-1:0] idx);
    return (idx == '0) ? IW'(NTAP - 1) : idx - 1'b1;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate fed by the RAM read ports. Issue controls are delayed
// by one cycle internally to line up with the one-cycle RAM read latency.
module fir_mac
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_vld,
  input  logic          issue_first,
  input  logic [DW-1:0] coef,
  input  logic [DW-1:0] sample,
  output logic [DW-1:0] acc
);

  logic          vld_reg;
  logic          first_reg;
  logic [DW-1:0] acc_reg;
  logic [DW-1:0] prod;

  // Only the low DW bits of the product are kept; the sum wraps freely.
  always_comb prod = $signed(coef) * $signed(sample);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg   <= 1'b0;
      first_reg <= 1'b0;
      acc_reg   <= '0;
    end else begin
      vld_reg   <= issue_vld;
      first_reg <= issue_first;
      if (vld_reg)
        acc_reg <= first_reg ? prod : acc_reg + prod;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/fir_engine.sv
// FIR control stage: clears the sample RAM, accepts samples over AXI-Stream,
// walks both RAMs through the MAC and returns one filtered word per input.
module fir_engine
  import fir_pkg::*;
(
  input  logic          axis_clk,
  input  logic          axis_rst_n,
  input  logic          ap_start,
  input  logic [31:0]   data_length,
  output logic          ap_done,
  output logic          ap_idle,
  input  logic          ss_tvalid,
  output logic          ss_tready,
  input  logic [DW-1:0] ss_tdata,
  input  logic          ss_tlast,
  output logic          sm_tvalid,
  input  logic          sm_tready,
  output logic [DW-1:0] sm_tdata,
  output logic          sm_tlast,
  output logic          tap_EN,
  output logic [3:0]    tap_WE,
  output logic [AW-1:0] tap_A,
  output logic [31:0]   tap_Di,
  input  logic [31:0]   tap_Do,
  output logic          data_EN,
  output logic [3:0]    data_WE,
  output logic [AW-1:0] data_A,
  output logic [31:0]   data_Di,
  input  logic [31:0]   data_Do
);

  logic [2:0]    state_reg;
  logic [IW-1:0] idx_reg;
  logic [IW-1:0] wp_reg;
  logic [IW-1:0] rp_reg;
  logic [31:0]   len_reg;
  logic [31:0]   cnt_reg;
  logic [DW-1:0] acc;
  logic          last_out;
  logic          unused_ok;

  assign unused_ok = ss_tlast;
  assign last_out  = (cnt_reg == len_reg - 32'd1);

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      wp_reg    <= '0;
      rp_reg    <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (ap_start) begin
          len_reg   <= data_length;
          idx_reg   <= '0;
          wp_reg    <= '0;
          cnt_reg   <= '0;
          state_reg <= S_CLEAR;
        end
        S_CLEAR: begin
          if (idx_reg == IW'(NTAP - 1)) begin
            idx_reg   <= '0;
            state_reg <= (len_reg == 32'd0) ? S_DONE : S_WAIT_X;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        S_WAIT_X: if (ss_tvalid) begin
          rp_reg    <= wp_reg;
          idx_reg   <= '0;
          state_reg <= S_MAC;
        end
        S_MAC: begin
          // Newest sample pairs with tap 0, walking backwards through the ring.
          rp_reg <= dec_mod_ntap(rp_reg);
          if (idx_reg == IW'(NTAP - 1)) begin
            idx_reg   <= '0;
            state_reg <= S_DRAIN;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        S_DRAIN: state_reg <= S_OUT;
        S_OUT: if (sm_tready) begin
          wp_reg    <= (wp_reg == IW'(NTAP - 1)) ? '0 : wp_reg + 1'b1;
          cnt_reg   <= cnt_reg + 32'd1;
          state_reg <= last_out ? S_DONE : S_WAIT_X;
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ap_done   = (state_reg == S_DONE);
    ap_idle   = (state_reg == S_IDLE);
    ss_tready = (state_reg == S_WAIT_X);
    sm_tvalid = (state_reg == S_OUT);
    sm_tdata  = (state_reg == S_OUT) ? acc : '0;
    sm_tlast  = (state_reg == S_OUT) && last_out;
    tap_EN    = (state_reg == S_MAC) || (state_reg == S_DRAIN);
    tap_WE    = 4'h0;
    tap_A     = (state_reg == S_MAC) ? byte_addr(idx_reg) : '0;
    tap_Di    = 32'h0;
    data_EN   = 1'b0;
    data_WE   = 4'h0;
    data_A    = '0;
    data_Di   = 32'h0;
    case (state_reg)
      S_CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = byte_addr(idx_reg);
      end
      S_WAIT_X: begin
        data_EN = ss_tvalid;
        data_WE = ss_tvalid ? 4'hF : 4'h0;
        data_A  = byte_addr(wp_reg);
        data_Di = ss_tvalid ? ss_tdata : 32'h0;
      end
      S_MAC: begin
        data_EN = 1'b1;
        data_A  = byte_addr(rp_reg);
      end
      S_DRAIN: data_EN = 1'b1;
      default: data_EN = 1'b0;
    endcase
  end

  fir_mac u_mac (
    .clk         (axis_clk),
    .rst_n       (axis_rst_n),
    .issue_vld   (state_reg == S_MAC),
    .issue_first ((state_reg == S_MAC) && (idx_reg == '0)),
    .coef        (tap_Do),
    .sample      (data_Do),
    .acc         (acc)
  );

endmodule

// File: doc/fir_engine.md
# fir_engine

Control and datapath stage for the 11-tap FIR, directly downstream of the two 11-word block RAMs (one holding coefficients, one a circular buffer of input samples). Accepts samples on an AXI-Stream slave and writes each one into the data RAM. Reads the coefficient and data RAMs word by word, multiply-accumulates, and emits one filtered output per input on an AXI-Stream master. An ap_start / ap_done / ap_idle handshake frames a run of `data_length` samples.

## Interface
- `NTAP`, 11, taps and data-buffer depth (fixed at 11 by the RAMs)
- `DW`, 32, sample, coefficient and accumulator width
- `axis_clk` in 1: sole clock
- `axis_rst_n` in 1: asynchronous, active-low reset
- `ap_start` in 1: one-cycle start pulse, honoured only while idle
- `data_length` in 32: samples per run, sampled on accepted ap_start
- `ap_done` out 1: one-cycle pulse when the run completes
- `ap_idle` out 1: high in IDLE
- `ss_tvalid`/`ss_tready` in/out 1, `ss_tdata` in DW, `ss_tlast` in 1: input stream (tlast ignored)
- `sm_tvalid`/`sm_tready` out/in 1, `sm_tdata` out DW, `sm_tlast` out 1: output stream
- `tap_EN` out 1, `tap_WE` out 4, `tap_A` out 12, `tap_Di` out 32, `tap_Do` in 32: coefficient RAM port; read-only, so WE=0 and Di=0 always
- `data_EN` out 1, `data_WE` out 4, `data_A` out 12, `data_Di` out 32, `data_Do` in 32: sample RAM port

## Operation
- RAMs are byte-addressed: `A = index*4`. Reads have one-cycle latency: the address registers at the edge, and Do is valid the following cycle only while EN stays high.
- Reset values: ss_tready=0, sm_tvalid=0, sm_tdata=0, sm_tlast=0, ap_done=0, ap_idle=1, all EN/WE/A/Di=0, write pointer wp=0, sample count=0, state IDLE.
- Reset does not clear RAM contents, which is why CLEAR exists.
- FSM:
  - IDLE → CLEAR on ap_start; latch data_length.
  - CLEAR: 11 cycles writing 0 to data[0..10] with WE=4'hF; set wp=0. Then → DONE if length=0, else → WAIT_X.
  - WAIT_X: ss_tready=1. On handshake, write ss_tdata to data[wp] (WE=4'hF) in the same cycle; → MAC.
  - MAC: 11 cycles, i=0..10. Issue tap_A=i*4 and data_A=((wp−i) mod 11)*4; acc clears at i=0. → DRAIN after i=10.
  - DRAIN: one cycle that accumulates the final product; → OUT.
  - OUT: sm_tvalid=1, sm_tdata=acc, sm_tlast=(count==length−1). On handshake: wp=(wp==10)?0:wp+1; count++. Then → DONE if last, else → WAIT_X.
  - DONE: ap_done=1 for one cycle; → IDLE.
- Accumulation: `acc += tap_Do * data_Do`, signed. Keep the low DW bits of each product; the accumulator wraps mod 2^DW with no saturation.
- EN stays high from the first MAC address cycle through DRAIN.
- ap_start is ignored outside IDLE.
- sm_tdata and sm_tlast are held stable while sm_tvalid=1 and sm_tready=0.
- Asynchronous reset mid-run aborts immediately to the reset values. A new run re-clears the data RAM.

## Timing
- Sample accepted at cycle T:
  - MAC address cycles T+1..T+11.
  - Products accumulate T+2..T+12 (DRAIN is T+12).
  - sm_tvalid rises at T+13.
- Minimum interval: 14 cycles per sample with sm_tready held high.
- ss_tready=0 in every state except WAIT_X.
- ap_done pulses the cycle after the final OUT handshake.
- Run with data_length=0: ap_done pulses 12 cycles after ap_start (11 CLEAR + 1).

## Structure
- `fir_pkg` holds:
  - NTAP and DW constants
  - the state enum (IDLE, CLEAR, WAIT_X, MAC, DRAIN, OUT, DONE)
  - the byte-address helper
  - the modulo-11 decrement function
- Sub-module `fir_mac` holds the signed multiply, the accumulator, and the clear/enable controls. The FSM and address generation stay in `fir_engine`.
- The bench instantiates two behavioural 11-word RAM models on the tap and data ports.

## Test plan
- Impulse: taps 1..11, input 1,0×10, length 11 → outputs 1,2,…,11; sm_tlast only on the 11th.
- All taps=1, inputs 1..20, length 20 → running window sums 1,3,6,…,66, then 77,88,…,165. Exercises wp wrap-around.
- Backpressure: sm_tready low for 5 cycles during OUT → sm_tdata stable, ss_tready stays 0, no sample lost or duplicated.
- Negative and overflow: tap=−1, input 0x7FFFFFFF → output 0x80000001; tap=2 with the same input → 0xFFFFFFFE (wrap).
- Reset mid-MAC, then a new run with impulse input → clean impulse response with no stale samples; all outputs at reset values during reset.
- data_length=0 → no ss_tready and no sm_tvalid; ap_done at start+12; ap_start while busy has no effect.
